// File: rtl/wash_seq.sv
// rtl/wash_seq.sv - wash-cycle sequencer (charge, WASH/RINSE/SPIN countdown, pause); DOOR_LOCK_EN adds door_open/lock
module wash_seq #(
    parameter int SEC_DIV = 100000000,
    parameter int WASH_S  = 12,
    parameter int RINSE_S = 8,
    parameter int SPIN_S  = 5,
    parameter int PRICE0  = 10,
    parameter int PRICE1  = 6,
    parameter int PRICE2  = 4,
    parameter int PRICE3  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic [1:0]  mode,
    input  logic [4:0]  set_min,
    input  logic [11:0] bal_in,
    output logic [11:0] bal_out,
    output logic [2:0]  phase,
    output logic [10:0] remain,
    output logic        busy,
    output logic        paused,
    output logic        done,
    output logic        err
`ifdef DOOR_LOCK_EN
    ,
    input  logic        door_open,
    output logic        lock
`endif
);

    typedef enum logic [2:0] {IDLE, CHARGE, WASH, RINSE, SPIN, PAUSED, FIN} state_t;

    localparam logic [26:0] DIV_LAST  = 27'(SEC_DIV - 1);
    localparam logic [10:0] WASH_LEN  = 11'(WASH_S);
    localparam logic [10:0] RINSE_LEN = 11'(RINSE_S);
    localparam logic [10:0] SPIN_LEN  = 11'(SPIN_S);

    state_t             state;
    logic [1:0]         mode_r;
    logic [4:0]         min_r;
    logic signed [11:0] bal_r;
    logic [26:0]        tick;
    logic [2:0]         saved;

    logic signed [11:0] price;
    logic [10:0]        min_len;
    logic [10:0]        wash_len;
    logic [10:0]        spin_len;
    state_t             first_st;
    state_t             nxt_st;
    state_t             resume_st;
    logic               bad;
    logic               pause_req;
    logic               resume_req;

    function automatic logic [2:0] light_of(state_t s);
        case (s)
            WASH:    light_of = 3'b001;
            RINSE:   light_of = 3'b010;
            SPIN:    light_of = 3'b100;
            default: light_of = 3'b000;
        endcase
    endfunction

    function automatic logic [10:0] len_of(state_t s, logic [10:0] wl, logic [10:0] sl);
        case (s)
            WASH:    len_of = wl;
            RINSE:   len_of = RINSE_LEN;
            SPIN:    len_of = sl;
            default: len_of = 11'd0;
        endcase
    endfunction

    // Price lookup, phase lengths, phase ordering and the charge/pause decisions
    always_comb begin
        case (mode_r)
            2'd0:    price = 12'(PRICE0);
            2'd1:    price = 12'(PRICE1);
            2'd2:    price = 12'(PRICE2);
            default: price = 12'(PRICE3);
        endcase
        min_len  = 11'(min_r) * 11'd60;
        wash_len = (mode_r == 2'd1) ? min_len : WASH_LEN;
        spin_len = (mode_r == 2'd2) ? min_len : SPIN_LEN;
        case (mode_r)
            2'd0, 2'd1: first_st = WASH;
            2'd2:       first_st = SPIN;
            default:    first_st = RINSE;
        endcase
        case (state)
            WASH:    nxt_st = (mode_r == 2'd0) ? RINSE : FIN;
            RINSE:   nxt_st = SPIN;
            default: nxt_st = FIN;
        endcase
        case (saved)
            3'b001:  resume_st = WASH;
            3'b010:  resume_st = RINSE;
            default: resume_st = SPIN;
        endcase
        bad = (bal_r < price) ||
              (((mode_r == 2'd1) || (mode_r == 2'd2)) && ((min_r == 5'd0) || (min_r > 5'd20)));
`ifdef DOOR_LOCK_EN
        bad        = bad || door_open;
        pause_req  = pause || door_open;
        resume_req = pause && !door_open;
`else
        pause_req  = pause;
        resume_req = pause;
`endif
    end

`ifdef DOOR_LOCK_EN
    assign lock = busy;
`endif

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_r  <= 2'd0;
            min_r   <= 5'd0;
            bal_r   <= 12'sd0;
            tick    <= 27'd0;
            saved   <= 3'b000;
            bal_out <= 12'd0;
            phase   <= 3'b000;
            remain  <= 11'd0;
            busy    <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        min_r  <= set_min;
                        bal_r  <= bal_in;
                        busy   <= 1'b1;
                        state  <= CHARGE;
                    end
                end
                CHARGE: begin
                    if (bad) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        bal_out <= bal_r - price;
                        remain  <= len_of(first_st, wash_len, spin_len);
                        phase   <= light_of(first_st);
                        tick    <= 27'd0;
                        state   <= first_st;
                    end
                end
                WASH, RINSE, SPIN: begin
                    // A pause on the wrap cycle wins: count and remain stay frozen
                    if (pause_req) begin
                        saved  <= phase;
                        paused <= 1'b1;
                        state  <= PAUSED;
                    end else if (tick == DIV_LAST) begin
                        tick <= 27'd0;
                        if (remain == 11'd1) begin
                            if (nxt_st == FIN) begin
                                phase  <= 3'b000;
                                remain <= 11'd0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                state  <= FIN;
                            end else begin
                                phase  <= light_of(nxt_st);
                                remain <= len_of(nxt_st, wash_len, spin_len);
                                state  <= nxt_st;
                            end
                        end else begin
                            remain <= remain - 11'd1;
                        end
                    end else begin
                        tick <= tick + 27'd1;
                    end
                end
                PAUSED: begin
                    if (resume_req) begin
                        paused <= 1'b0;
                        state  <= resume_st;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_seq.sv
// tb/tb_wash_seq.sv - self-checking bench for wash_seq: vector table, corner sequences, randomized runs vs reference model
module tb_wash_seq;

    localparam int SD = 4;
    localparam int WS = 3;
    localparam int RS = 2;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [4:0]  set_min = 5'd0;
    logic [11:0] bal_in = 12'd0;
    logic [11:0] bal_out;
    logic [2:0]  phase;
    logic [10:0] remain;
    logic        busy, paused, done, err;
    logic        door_open = 1'b0;
`ifdef DOOR_LOCK_EN
    logic        lock;
`endif

    wash_seq #(
        .SEC_DIV(SD), .WASH_S(WS), .RINSE_S(RS), .SPIN_S(SS),
        .PRICE0(10), .PRICE1(6), .PRICE2(4), .PRICE3(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .mode(mode),
        .set_min(set_min), .bal_in(bal_in), .bal_out(bal_out), .phase(phase),
        .remain(remain), .busy(busy), .paused(paused), .done(done), .err(err)
`ifdef DOOR_LOCK_EN
        , .door_open(door_open), .lock(lock)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ms 0 idle, 1 charge, 2 running, 3 paused, 4 finished.
    // e = running cycles elapsed in the cycle; phase/remain are derived from e.
    int ms = 0, e = 0, np = 1, tot = 0;
    int plen[3];
    int plt[3];
    int sm_m = 0, sm_min = 0, sm_bal = 0, bal_o = 0, err_e = 0, run_seen = 0;

    typedef struct {
        int m; int sm; int b; int e_err; int e_bal; int e_busy;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; e = 0; np = 1; tot = 0; bal_o = 0; err_e = 0;
        for (int i = 0; i < 3; i++) begin plen[i] = 0; plt[i] = 0; end
    endtask

    task automatic model_step(input bit st, input bit pa);
        int price;
        bit bad;
        err_e = 0;
        case (ms)
            0: if (st) begin
                sm_m = mode; sm_min = set_min; sm_bal = $signed(bal_in); ms = 1;
            end
            1: begin
                price = (sm_m == 0) ? 10 : (sm_m == 1) ? 6 : (sm_m == 2) ? 4 : 8;
                bad = (sm_bal < price) || ((sm_m == 1 || sm_m == 2) && (sm_min < 1 || sm_min > 20)) || door_open;
                if (bad) begin
                    err_e = 1; ms = 0;
                end else begin
                    bal_o = (sm_bal - price) & 12'hFFF;
                    case (sm_m)
                        0: begin np = 3; plen[0] = WS; plen[1] = RS; plen[2] = SS; plt[0] = 1; plt[1] = 2; plt[2] = 4; end
                        1: begin np = 1; plen[0] = sm_min * 60; plt[0] = 1; end
                        2: begin np = 1; plen[0] = sm_min * 60; plt[0] = 4; end
                        default: begin np = 2; plen[0] = RS; plen[1] = SS; plt[0] = 2; plt[1] = 4; end
                    endcase
                    tot = 0;
                    for (int i = 0; i < np; i++) tot += plen[i] * SD;
                    e = 0; ms = 2;
                end
            end
            2: if (pa || door_open) ms = 3;
               else begin e++; if (e == tot) ms = 4; end
            3: if (pa && !door_open) ms = 2;
            default: ms = 0;
        endcase
    endtask

    task automatic check_all();
        int idx, cum, el, er;
        el = 0; er = 0;
        if (ms == 2 || ms == 3) begin
            idx = 0; cum = 0;
            while (idx < np - 1 && e >= cum + plen[idx] * SD) begin
                cum += plen[idx] * SD; idx++;
            end
            el = plt[idx];
            er = plen[idx] - (e - cum) / SD;
        end
        chk("phase", phase, el);
        chk("remain", remain, er);
        chk("busy", busy, (ms >= 1 && ms <= 3));
        chk("paused", paused, (ms == 3));
        chk("done", done, (ms == 4));
        chk("err", err, err_e);
        chk("bal_out", bal_out, bal_o);
`ifdef DOOR_LOCK_EN
        chk("lock", lock, (ms >= 1 && ms <= 3));
`endif
        if (phase != 3'b000 && !paused) run_seen++;
    endtask

    task automatic cyc(input bit st, input bit pa);
        start = st; pause = pa;
        model_step(st, pa);
        @(negedge clk);
        start = 1'b0; pause = 1'b0;
        check_all();
    endtask

    task automatic advance_to(input int t);
        for (int k = 0; k < 200 && !(ms == 2 && e == t); k++) cyc(1'b0, 1'b0);
        chk("reach_e", e, t);
    endtask

    task automatic run_vec(input int m, input int sm, input int b, input bit rnd,
                           output int nb, output int saw_err);
        bit fin;
        mode = 2'(m); set_min = 5'(sm); bal_in = 12'(b);
        cyc(1'b1, 1'b0);
        nb = 0; fin = 0; saw_err = 0;
        for (int k = 0; k < 20000 && !fin; k++) begin
            if (busy) nb++;
            if (done || err) begin fin = 1; saw_err = err; end
            else if (rnd) cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            else cyc(1'b0, 1'b0);
        end
        if (!fin) chk("run_timeout", 0, 1);
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, se, m, sm, b;
        vt[0] = '{0, 0,   9, 1,  0,    1};
        vt[1] = '{0, 0,  15, 0,  5,   29};
        vt[2] = '{1, 0,  50, 1,  5,    1};
        vt[3] = '{1, 1,  50, 0, 44,  241};
        vt[4] = '{2, 21, 50, 1, 44,    1};
        vt[5] = '{2, 2,   4, 0,  0,  481};
        vt[6] = '{3, 0,   8, 0,  0,   17};
        vt[7] = '{3, 0,   7, 1,  0,    1};
        vt[8] = '{0, 0,  -5, 1,  0,    1};
        vt[9] = '{1, 20,  6, 0,  0, 4801};

        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b0;
        @(negedge clk);
        check_all();

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i].m, vt[i].sm, vt[i].b, 1'b0, nb, se);
            chk($sformatf("vec%0d_err", i), se, vt[i].e_err);
            chk($sformatf("vec%0d_bal", i), bal_out, vt[i].e_bal);
            chk($sformatf("vec%0d_busy_cycles", i), nb, vt[i].e_busy);
        end

        // Pause on a tick-wrap cycle in WASH at remain=2, hold 20 clk, resume
        mode = 2'd0; bal_in = 12'd20; run_seen = 0;
        cyc(1'b1, 1'b0);
        advance_to(7);
        chk("pause_pre_remain", remain, 2);
        cyc(1'b0, 1'b1);
        chk("pause_wrap_remain", remain, 2);
        chk("pause_paused", paused, 1);
        repeat (20) cyc(1'b0, 1'b0);
        chk("pause_hold_remain", remain, 2);
        chk("pause_hold_phase", phase, 1);
        cyc(1'b0, 1'b1);
        chk("resume_paused", paused, 0);
        for (int k = 0; k < 200 && !done; k++) cyc(1'b0, 1'b0);
        chk("pause_done", done, 1);
        chk("pause_run_cycles", run_seen, 29);
        cyc(1'b0, 1'b0);

        // Asynchronous reset in RINSE clears everything immediately
        cyc(1'b1, 1'b0);
        advance_to(14);
        chk("rinse_phase", phase, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_phase", phase, 0);
        chk("rst_remain", remain, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bal", bal_out, 0);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        @(negedge clk);
        check_all();

`ifdef DOOR_LOCK_EN
        // Door opened in SPIN pauses; pause cannot resume while the door is open
        mode = 2'd0; bal_in = 12'd20;
        cyc(1'b1, 1'b0);
        advance_to(21);
        door_open = 1'b1;
        cyc(1'b0, 1'b0);
        chk("door_paused", paused, 1);
        chk("door_lock", lock, 1);
        cyc(1'b0, 1'b1);
        chk("door_blocked", paused, 1);
        door_open = 1'b0;
        cyc(1'b0, 1'b1);
        chk("door_resume", paused, 0);
        for (int k = 0; k < 200 && !done; k++) cyc(1'b0, 1'b0);
        chk("door_done", done, 1);
        cyc(1'b0, 1'b0);
`endif

        // Randomized runs with stray start and pause pulses
        for (int r = 0; r < 12; r++) begin
            m  = $urandom_range(0, 3);
            sm = $urandom_range(0, 6);
            if (sm == 6) sm = 21;
            b  = int'($urandom_range(0, 80)) - 20;
            run_vec(m, sm, b, 1'b1, nb, se);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
